// File: rtl/ras_ckpt.sv
// Return address stack with checkpoint restore for branch mispredict recovery.
// Define RAS_ENTRY_RESET_EN to clear the entry array on reset; by default the array has no reset.
module ras_ckpt #(
  parameter int RAS_ENTRIES      = 8,
  parameter int RAS_INDEX_WIDTH  = 3,
  parameter int RAS_TARGET_WIDTH = 31
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        push_req,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_req,
  input  logic                        restore_valid,
  input  logic [RAS_INDEX_WIDTH-1:0]  restore_index,
  input  logic [RAS_INDEX_WIDTH:0]    restore_count,
  output logic [RAS_TARGET_WIDTH-1:0] top_target,
  output logic                        top_valid,
  output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
  output logic [RAS_INDEX_WIDTH:0]    ras_count
);

  localparam logic [RAS_INDEX_WIDTH:0] FULL_COUNT = (RAS_INDEX_WIDTH+1)'(RAS_ENTRIES);

  logic [RAS_TARGET_WIDTH-1:0] entries [RAS_ENTRIES];
  logic [RAS_INDEX_WIDTH-1:0]  index_q, index_d, index_inc, index_dec;
  logic [RAS_INDEX_WIDTH:0]    count_q, count_d;
  logic                        not_empty;
  logic                        entry_we;
  logic [RAS_INDEX_WIDTH-1:0]  entry_waddr;

  assign index_inc = index_q + RAS_INDEX_WIDTH'(1);
  assign index_dec = index_q - RAS_INDEX_WIDTH'(1);
  assign not_empty = (count_q != '0);

  // Restore has priority; a push at full wraps the pointer onto the oldest entry.
  always_comb begin
    index_d     = index_q;
    count_d     = count_q;
    entry_we    = 1'b0;
    entry_waddr = index_q;
    if (restore_valid) begin
      index_d = restore_index;
      count_d = (restore_count > FULL_COUNT) ? FULL_COUNT : restore_count;
    end else if (push_req && pop_req && not_empty) begin
      entry_we    = 1'b1;
      entry_waddr = index_dec;
    end else if (push_req) begin
      entry_we = 1'b1;
      index_d  = index_inc;
      if (count_q != FULL_COUNT) begin
        count_d = count_q + (RAS_INDEX_WIDTH+1)'(1);
      end
    end else if (pop_req && not_empty) begin
      index_d = index_dec;
      count_d = count_q - (RAS_INDEX_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      index_q <= '0;
      count_q <= '0;
    end else begin
      index_q <= index_d;
      count_q <= count_d;
    end
  end

`ifdef RAS_ENTRY_RESET_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        entries[i] <= '0;
      end
    end else if (entry_we) begin
      entries[entry_waddr] <= push_target;
    end
  end
`else
  // Writes are still blocked during reset so a push in the reset cycle is dropped.
  always_ff @(posedge CLK) begin
    if (nRST && entry_we) begin
      entries[entry_waddr] <= push_target;
    end
  end
`endif

  assign top_target = entries[index_dec];
  assign top_valid  = not_empty;
  assign ras_index  = index_q;
  assign ras_count  = count_q;

endmodule

// File: doc/ras_ckpt.md
RAS_CKPT -- requirements
Module: ras_ckpt

Interface
REQ-001 SHALL take parameter RAS_ENTRIES, default 8: stack depth; must be a power of 2.
REQ-002 SHALL take parameter RAS_INDEX_WIDTH, default 3: log2(RAS_ENTRIES).
REQ-003 SHALL take parameter RAS_TARGET_WIDTH, default 31: return target, PC[31:1].
REQ-004 SHALL have one clock; reset is synchronous and active-low. Ports: CLK  in  1  clock; nRST  in  1  sync active-low reset.
REQ-005 SHALL have port push_req  in  1: push a return target (call).
REQ-006 SHALL have port push_target  in  RAS_TARGET_WIDTH: target to push.
REQ-007 SHALL have port pop_req  in  1: pop the top of stack (return).
REQ-008 SHALL have port restore_valid  in  1: mispredict recovery from checkpoint.
REQ-009 SHALL have port restore_index  in  RAS_INDEX_WIDTH: checkpointed index.
REQ-010 SHALL have port restore_count  in  RAS_INDEX_WIDTH+1: checkpointed occupancy.
REQ-011 SHALL have port top_target  out  RAS_TARGET_WIDTH: entry[index-1], modulo RAS_ENTRIES.
REQ-012 SHALL have port top_valid  out  1: count != 0.
REQ-013 SHALL have port ras_index  out  RAS_INDEX_WIDTH: current write pointer, for checkpointing.
REQ-014 SHALL have port ras_count  out  RAS_INDEX_WIDTH+1: occupancy, 0..RAS_ENTRIES.

Function
REQ-015 SHALL hold state as entry array, index register and count register; all outputs SHALL be combinational from state only, with no input-to-output paths.
REQ-016 Push only: SHALL write entry[index]<=push_target, index<=index+1 (wraps), count<=min(count+1, RAS_ENTRIES).
REQ-017 Push at full (count==RAS_ENTRIES): SHALL overwrite the oldest entry and keep count at RAS_ENTRIES.
REQ-018 Pop only with count>0: SHALL set index<=index-1 (wraps) and count<=count-1; array unchanged.
REQ-019 Pop only with count==0 (underflow): SHALL leave index, count and array unchanged.
REQ-020 Push and pop together with count>0: SHALL write entry[index-1]<=push_target and leave index and count unchanged.
REQ-021 Push and pop together with count==0: SHALL behave as push only.
REQ-022 restore_valid: SHALL load index<=restore_index and count<=min(restore_count, RAS_ENTRIES); array unchanged; push_req and pop_req ignored that cycle.
REQ-023 Updates SHALL be visible on outputs the cycle after the request edge (1-cycle latency).

Reset
REQ-024 On CLK rising edge with nRST==0: index<=0, count<=0; thus ras_index=0, ras_count=0, top_valid=0.
REQ-025 Reset SHALL override restore_valid, push_req and pop_req in the same cycle.
REQ-026 Without RAS_ENTRY_RESET_EN, array contents and top_target after reset SHALL be unspecified.

Configuration
REQ-027 Macro RAS_ENTRY_RESET_EN defined: all array entries SHALL reset to 0, so top_target=0 after reset.
REQ-028 RAS_ENTRY_RESET_EN undefined: array SHALL have no reset, for area; all other behaviour is identical.

Verification
REQ-029 Reset, then push 0x100, 0x200, 0x300 -> index=3, count=3, top_target=0x300, top_valid=1; three pops -> top 0x200, then 0x100, then top_valid=0.
REQ-030 Push 9 targets 0x1..0x9 -> count=8, index=1, top=0x9; 8 pops return 0x9..0x2; 9th pop -> count=0, state unchanged.
REQ-031 count=2, top=0x20; push+pop with 0x55 -> top=0x55, count=2, index unchanged; with count=0 -> top=0x55, count=1.
REQ-032 After 5 pushes, restore_valid with index=2, count=2 while push_req=1 -> index=2, count=2, top = 2nd pushed value, no push applied.
REQ-033 nRST low mid-sequence with push_req=1 -> index=0, count=0, top_valid=0; with RAS_ENTRY_RESET_EN also top_target=0.
